// File: rtl/exu_wakeup_bcast_pkg.sv
// Shared tag widths, latencies and divider FSM encodings for the EXU
// wakeup broadcast logic.
package exu_wakeup_bcast_pkg;

    localparam int PREG_W   = 6;
    localparam int MUL_LAT  = 3;
    localparam int DIV_LAT  = 18;
    localparam int DIV_FAST = 3;

    localparam logic [0:0] DIV_IDLE = 1'b0;
    localparam logic [0:0] DIV_BUSY = 1'b1;

    // A broadcast with vld low always carries an all-zero tag.
    function automatic logic [PREG_W-1:0] mask_preg(input logic vld,
                                                    input logic [PREG_W-1:0] preg);
        return vld ? preg : '0;
    endfunction

endpackage

// File: rtl/exu_div_wakeup_fsm.sv
// Divider wakeup timing: IDLE/BUSY FSM with a down-counter that emits the
// div1/div2 forward hints and the div3 result tag at the end of a divide.
module exu_div_wakeup_fsm
    import exu_wakeup_bcast_pkg::*;
#(
    parameter int P_PREG_W   = PREG_W,
    parameter int P_DIV_LAT  = DIV_LAT,
    parameter int P_DIV_FAST = DIV_FAST
) (
    input  logic                clk,
    input  logic                rst_clk,
    input  logic                flush,
    input  logic                issue_vld,
    input  logic                issue_dst_vld,
    input  logic [P_PREG_W-1:0] issue_preg,
    input  logic                issue_fast,
    output logic                div_ready,
    output logic                div1_vld,
    output logic [P_PREG_W-1:0] div1_preg,
    output logic                div2_vld,
    output logic [P_PREG_W-1:0] div2_preg,
    output logic                div3_vld,
    output logic [P_PREG_W-1:0] div3_preg
);

    localparam int CNT_W = $clog2(P_DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_NORM = CNT_W'(P_DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_FAST = CNT_W'(P_DIV_FAST - 1);

    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dst_vld_q, dst_vld_d;
    logic [P_PREG_W-1:0] preg_q, preg_d;
    logic                div1_vld_q, div1_vld_d;
    logic [P_PREG_W-1:0] div1_preg_q, div1_preg_d;
    logic                div2_vld_q, div2_vld_d;
    logic [P_PREG_W-1:0] div2_preg_q, div2_preg_d;
    logic                div3_vld_q, div3_vld_d;
    logic [P_PREG_W-1:0] div3_preg_q, div3_preg_d;

    // Next-state: accept an issue in IDLE, count down in BUSY, and leave BUSY
    // as the result tag is launched so a new divide can issue that cycle.
    // The forward hints are derived from the next count so they line up
    // exactly two and one cycles ahead of the result.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dst_vld_d = dst_vld_q;
        preg_d    = preg_q;
        if (flush) begin
            state_d   = DIV_IDLE;
            cnt_d     = '0;
            dst_vld_d = 1'b0;
            preg_d    = '0;
        end else if (state_q == DIV_IDLE) begin
            if (issue_vld) begin
                state_d   = DIV_BUSY;
                cnt_d     = issue_fast ? CNT_FAST : CNT_NORM;
                dst_vld_d = issue_dst_vld;
                preg_d    = issue_preg;
            end
        end else begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (cnt_q <= CNT_W'(1)) begin
                state_d = DIV_IDLE;
            end
        end

        div1_vld_d  = (state_d == DIV_BUSY) && dst_vld_d && (cnt_d == CNT_W'(2));
        div2_vld_d  = (state_d == DIV_BUSY) && dst_vld_d && (cnt_d == CNT_W'(1));
        div3_vld_d  = !flush && (state_q == DIV_BUSY) && dst_vld_q && (cnt_q == CNT_W'(1));
        div1_preg_d = div1_vld_d ? preg_d : '0;
        div2_preg_d = div2_vld_d ? preg_d : '0;
        div3_preg_d = div3_vld_d ? preg_q : '0;
    end

    // State, counter and broadcast registers; reset drops any divide in flight.
    always_ff @(posedge clk) begin
        if (rst_clk) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            dst_vld_q   <= 1'b0;
            preg_q      <= '0;
            div1_vld_q  <= 1'b0;
            div1_preg_q <= '0;
            div2_vld_q  <= 1'b0;
            div2_preg_q <= '0;
            div3_vld_q  <= 1'b0;
            div3_preg_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dst_vld_q   <= dst_vld_d;
            preg_q      <= preg_d;
            div1_vld_q  <= div1_vld_d;
            div1_preg_q <= div1_preg_d;
            div2_vld_q  <= div2_vld_d;
            div2_preg_q <= div2_preg_d;
            div3_vld_q  <= div3_vld_d;
            div3_preg_q <= div3_preg_d;
        end
    end

    // An issue while the divider is busy is an upstream bug; it is ignored.
    always_ff @(posedge clk) begin
        if (!rst_clk && !flush) begin
            assert (!(issue_vld && (state_q == DIV_BUSY)))
                else $error("div issued while divider busy");
        end
    end

    assign div_ready = (state_q == DIV_IDLE);
    assign div1_vld  = div1_vld_q;
    assign div1_preg = div1_preg_q;
    assign div2_vld  = div2_vld_q;
    assign div2_preg = div2_preg_q;
    assign div3_vld  = div3_vld_q;
    assign div3_preg = div3_preg_q;

endmodule

// File: rtl/exu_wakeup_bcast.sv
// EXU wakeup transmitter: drives mul/div forward and result tag broadcasts
// that issue-queue entries snoop to mark their sources ready.
module exu_wakeup_bcast
    import exu_wakeup_bcast_pkg::*;
(
    input  logic              clk,
    input  logic              rst_clk,
    input  logic              rtu_global_flush,
    input  logic              mul_issue_vld,
    input  logic              mul_issue_dst_vld,
    input  logic [PREG_W-1:0] mul_issue_preg,
    input  logic              div_issue_vld,
    input  logic              div_issue_dst_vld,
    input  logic [PREG_W-1:0] div_issue_preg,
    input  logic              div_issue_fast,
    output logic              div_ready,
    output logic              exu_idu_is_mul1_forward_vld,
    output logic [PREG_W-1:0] exu_idu_is_mul1_forward_preg,
    output logic              exu_idu_is_mul2_forward_vld,
    output logic [PREG_W-1:0] exu_idu_is_mul2_forward_preg,
    output logic              exu_idu_is_mul3_result_vld,
    output logic [PREG_W-1:0] exu_idu_is_mul3_result_preg,
    output logic              exu_idu_is_div1_forward_vld,
    output logic [PREG_W-1:0] exu_idu_is_div1_forward_preg,
    output logic              exu_idu_is_div2_forward_vld,
    output logic [PREG_W-1:0] exu_idu_is_div2_forward_preg,
    output logic              exu_idu_is_div3_result_vld,
    output logic [PREG_W-1:0] exu_idu_is_div3_result_preg
);

    logic              mul1_vld_q, mul1_vld_d;
    logic [PREG_W-1:0] mul1_preg_q, mul1_preg_d;
    logic              mul2_vld_q, mul2_vld_d;
    logic [PREG_W-1:0] mul2_preg_q, mul2_preg_d;
    logic              mul3_vld_q, mul3_vld_d;
    logic [PREG_W-1:0] mul3_preg_q, mul3_preg_d;

    // Multiplier tag shift chain; a flush empties every stage at once.
    always_comb begin
        mul1_vld_d  = !rtu_global_flush && mul_issue_vld && mul_issue_dst_vld;
        mul1_preg_d = mask_preg(mul1_vld_d, mul_issue_preg);
        mul2_vld_d  = !rtu_global_flush && mul1_vld_q;
        mul2_preg_d = mask_preg(mul2_vld_d, mul1_preg_q);
        mul3_vld_d  = !rtu_global_flush && mul2_vld_q;
        mul3_preg_d = mask_preg(mul3_vld_d, mul2_preg_q);
    end

    // Multiplier stage registers.
    always_ff @(posedge clk) begin
        if (rst_clk) begin
            mul1_vld_q  <= 1'b0;
            mul1_preg_q <= '0;
            mul2_vld_q  <= 1'b0;
            mul2_preg_q <= '0;
            mul3_vld_q  <= 1'b0;
            mul3_preg_q <= '0;
        end else begin
            mul1_vld_q  <= mul1_vld_d;
            mul1_preg_q <= mul1_preg_d;
            mul2_vld_q  <= mul2_vld_d;
            mul2_preg_q <= mul2_preg_d;
            mul3_vld_q  <= mul3_vld_d;
            mul3_preg_q <= mul3_preg_d;
        end
    end

    assign exu_idu_is_mul1_forward_vld  = mul1_vld_q;
    assign exu_idu_is_mul1_forward_preg = mul1_preg_q;
    assign exu_idu_is_mul2_forward_vld  = mul2_vld_q;
    assign exu_idu_is_mul2_forward_preg = mul2_preg_q;
    assign exu_idu_is_mul3_result_vld   = mul3_vld_q;
    assign exu_idu_is_mul3_result_preg  = mul3_preg_q;

    exu_div_wakeup_fsm #(
        .P_PREG_W   (PREG_W),
        .P_DIV_LAT  (DIV_LAT),
        .P_DIV_FAST (DIV_FAST)
    ) u_div_fsm (
        .clk           (clk),
        .rst_clk       (rst_clk),
        .flush         (rtu_global_flush),
        .issue_vld     (div_issue_vld),
        .issue_dst_vld (div_issue_dst_vld),
        .issue_preg    (div_issue_preg),
        .issue_fast    (div_issue_fast),
        .div_ready     (div_ready),
        .div1_vld      (exu_idu_is_div1_forward_vld),
        .div1_preg     (exu_idu_is_div1_forward_preg),
        .div2_vld      (exu_idu_is_div2_forward_vld),
        .div2_preg     (exu_idu_is_div2_forward_preg),
        .div3_vld      (exu_idu_is_div3_result_vld),
        .div3_preg     (exu_idu_is_div3_result_preg)
    );

endmodule
